// File: rtl/hack_sram_bridge.sv
// Bridges the Hack CPU data-memory port onto the SPI SRAM encoder's request/busy
// handshake, with a one-entry read cache and a request-acknowledge watchdog.
module hack_sram_bridge #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int ACK_TIMEOUT   = 8,
  parameter int CACHE_EN      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_mem_req,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic                     cpu_write,
  input  logic [WORD_WIDTH-1:0]    cpu_wdata,
  output logic [WORD_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     enc_request,
  input  logic                     enc_busy,
  input  logic                     enc_initialized,
  output logic [ADDRESS_WIDTH-1:0] enc_address,
  output logic                     enc_write_enable,
  output logic [WORD_WIDTH-1:0]    enc_wdata,
  input  logic [WORD_WIDTH-1:0]    enc_rdata,
  output logic                     ack_error
);

  localparam int WDOG_W = $clog2(ACK_TIMEOUT) + 1;
  // Leaving WAIT_BUSY when the counter is at ACK_TIMEOUT-2 makes the re-issue pulse
  // land exactly ACK_TIMEOUT cycles after the ignored one.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(ACK_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] enc_address_q;
  logic                     enc_write_enable_q;
  logic [WORD_WIDTH-1:0]    enc_wdata_q;
  logic [WORD_WIDTH-1:0]    rdata_q;
  logic                     cache_valid_q;
  logic [ADDRESS_WIDTH-1:0] cache_tag_q;
  logic [WORD_WIDTH-1:0]    cache_data_q;
  logic                     ack_error_q;
  logic [WDOG_W-1:0]        wdog_q;
  logic                     cache_hit;

  assign cache_hit = (CACHE_EN != 0) && cache_valid_q && (cache_tag_q == cpu_address) && !cpu_write;

  // Stall, zero-wait hit data and the single-cycle encoder request pulse.
  always_comb begin
    cpu_stall   = 1'b1;
    enc_request = 1'b0;
    cpu_rdata   = rdata_q;
    case (state_q)
      S_IDLE: begin
        cpu_stall = cpu_mem_req & ~cache_hit;
        if (cache_hit) begin
          cpu_rdata = cache_data_q;
        end else begin
          cpu_rdata = rdata_q;
        end
      end
      S_ISSUE: enc_request = enc_initialized & ~enc_busy;
      S_DONE:  cpu_stall   = 1'b0;
      default: cpu_stall   = 1'b1;
    endcase
  end

  // Transaction FSM, latched encoder fields, cache and watchdog.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= S_WAIT_INIT;
      enc_address_q      <= '0;
      enc_write_enable_q <= 1'b0;
      enc_wdata_q        <= '0;
      rdata_q            <= '0;
      cache_valid_q      <= 1'b0;
      cache_tag_q        <= '0;
      cache_data_q       <= '0;
      ack_error_q        <= 1'b0;
      wdog_q             <= '0;
    end else begin
      case (state_q)
        S_WAIT_INIT: begin
          if (enc_initialized) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (cpu_mem_req && !cache_hit) begin
            enc_address_q      <= cpu_address;
            enc_write_enable_q <= cpu_write;
            enc_wdata_q        <= cpu_wdata;
            state_q            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (enc_request) begin
            wdog_q  <= '0;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (enc_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
            if (wdog_q == WDOG_LAST) begin
              ack_error_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!enc_busy) begin
            // Writes allocate too, so a later read of the same word never sees stale data.
            cache_valid_q <= 1'b1;
            cache_tag_q   <= enc_address_q;
            if (enc_write_enable_q) begin
              cache_data_q <= enc_wdata_q;
            end else begin
              cache_data_q <= enc_rdata;
              rdata_q      <= enc_rdata;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_WAIT_INIT;
      endcase
    end
  end

  assign enc_address      = enc_address_q;
  assign enc_write_enable = enc_write_enable_q;
  assign enc_wdata        = enc_wdata_q;
  assign ack_error        = ack_error_q;

endmodule

// File: tb/tb_hack_sram_bridge.sv
// Directed bench for hack_sram_bridge: vector table of CPU accesses against a small
// encoder model, plus hand-written init, watchdog and mid-transaction reset sequences.
module tb_hack_sram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_req;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        enc_request;
  logic        enc_busy = 1'b0;
  logic        enc_initialized;
  logic [15:0] enc_address;
  logic        enc_write_enable;
  logic [15:0] enc_wdata;
  logic [15:0] enc_rdata;
  logic        ack_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_sram_bridge #(.WORD_WIDTH(16), .ADDRESS_WIDTH(16), .ACK_TIMEOUT(8), .CACHE_EN(1)) dut (
    .clk(clk), .reset(reset), .cpu_mem_req(cpu_mem_req), .cpu_address(cpu_address),
    .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .enc_request(enc_request), .enc_busy(enc_busy), .enc_initialized(enc_initialized),
    .enc_address(enc_address), .enc_write_enable(enc_write_enable), .enc_wdata(enc_wdata),
    .enc_rdata(enc_rdata), .ack_error(ack_error)
  );

  // Encoder model: goes busy for four cycles per accepted pulse, can ignore one pulse.
  int          req_count = 0;
  int          cyc = 0;
  int          ignore_at = -1;
  int          busy_cnt = 0;
  int          pulse_cyc [64];
  logic [15:0] pulse_addr[64];
  logic [15:0] pulse_wd  [64];
  logic        pulse_we  [64];
  logic [15:0] ret_data = 16'h0000;

  assign enc_rdata = ret_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      enc_busy <= 1'b0;
      busy_cnt <= 0;
    end else if (enc_request) begin
      if (req_count < 64) begin
        pulse_cyc[req_count]  <= cyc;
        pulse_addr[req_count] <= enc_address;
        pulse_wd[req_count]   <= enc_wdata;
        pulse_we[req_count]   <= enc_write_enable;
      end
      req_count <= req_count + 1;
      if (req_count != ignore_at) begin
        enc_busy <= 1'b1;
        busy_cnt <= 3;
      end
    end else if (enc_busy) begin
      if (busy_cnt == 0) enc_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one access right after a rising edge; returns the data seen when the stall
  // drops, the number of encoder pulses it took and the number of stalled cycles.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] ret, output logic [15:0] rd,
                        output int reqs, output int stalls);
    int r0;
    r0          = req_count;
    ret_data    = ret;
    cpu_mem_req = 1'b1;
    cpu_write   = wr;
    cpu_address = a;
    cpu_wdata   = d;
    stalls      = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    check("access_completes", (stalls < 100), 1);
    rd   = cpu_rdata;
    reqs = req_count - r0;
    @(posedge clk);
    #1;
    cpu_mem_req = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ret;
    int          exp_reqs;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] rd;
  int          reqs;
  int          stalls;
  int          k;
  int          n;
  logic        init_ok;

  initial begin
    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hDEAD, 0, 16'hBEEF};
    vecs[2] = '{1'b0, 16'h0020, 16'h0000, 16'h1234, 1, 16'h1234};
    vecs[3] = '{1'b0, 16'h0020, 16'h0000, 16'hDEAD, 0, 16'h1234};
    vecs[4] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'hBEEF};
    vecs[5] = '{1'b1, 16'h0010, 16'hA5A5, 16'h0000, 1, 16'h0000};
    vecs[6] = '{1'b0, 16'h0010, 16'h0000, 16'hDEAD, 0, 16'hA5A5};
    vecs[7] = '{1'b0, 16'h0030, 16'h0000, 16'h0F0F, 1, 16'h0F0F};
    vecs[8] = '{1'b1, 16'h0030, 16'h1111, 16'h0000, 1, 16'h0000};
    vecs[9] = '{1'b0, 16'h0030, 16'h0000, 16'hDEAD, 0, 16'h1111};

    reset = 1'b0; cpu_mem_req = 1'b0; cpu_address = 16'h0000; cpu_write = 1'b0;
    cpu_wdata = 16'h0000; enc_initialized = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", cpu_rdata, 0);
    check("reset_ack_error", ack_error, 0);
    check("reset_enc_request", enc_request, 0);
    check("reset_enc_address", enc_address, 0);
    check("reset_stall", cpu_stall, 1);

    // Encoder not initialised: the CPU stays stalled and nothing is requested.
    @(posedge clk); #1;
    reset = 1'b1; cpu_mem_req = 1'b1; cpu_address = 16'h0040; cpu_write = 1'b0;
    init_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_stall || enc_request) init_ok = 1'b0;
    end
    check("init_hold_stall_noreq", init_ok, 1);
    check("init_hold_req_count", req_count, 0);
    @(posedge clk); #1;
    enc_initialized = 1'b1;
    access(1'b0, 16'h0040, 16'h0000, 16'h4444, rd, reqs, stalls);
    check("init_one_request", reqs, 1);
    check("init_read_data", rd, 16'h4444);

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ret, rd, reqs, stalls);
      check($sformatf("vec%0d_requests", i), reqs, vecs[i].exp_reqs);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].exp_reqs == 0) check($sformatf("vec%0d_zero_wait", i), stalls, 0);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_enc_addr", i), pulse_addr[req_count-1], vecs[i].addr);
        check($sformatf("vec%0d_enc_we", i), pulse_we[req_count-1], 1);
        check($sformatf("vec%0d_enc_wdata", i), pulse_wd[req_count-1], vecs[i].wdata);
      end
    end
    check("ack_error_clear_before_timeout", ack_error, 0);

    // Encoder ignores the first pulse: re-issue 8 cycles later with the same fields.
    k = req_count;
    ignore_at = k;
    access(1'b1, 16'h0050, 16'h7777, 16'h0000, rd, reqs, stalls);
    check("wdog_requests", reqs, 2);
    check("wdog_gap", pulse_cyc[k+1] - pulse_cyc[k], 8);
    check("wdog_same_addr", pulse_addr[k+1], 16'h0050);
    check("wdog_same_we", pulse_we[k+1], 1);
    check("wdog_same_wdata", pulse_wd[k+1], 16'h7777);
    check("wdog_ack_error", ack_error, 1);
    access(1'b0, 16'h0050, 16'h0000, 16'hDEAD, rd, reqs, stalls);
    check("wdog_hit_after", rd, 16'h7777);
    check("ack_error_sticky", ack_error, 1);

    // Reset while the encoder is busy on a read miss.
    ret_data = 16'h6666; cpu_mem_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0060;
    n = 0;
    while (!enc_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midreset_busy_seen", (n < 50), 1);
    @(negedge clk);
    reset = 1'b0; cpu_mem_req = 1'b0;
    @(negedge clk);
    check("midreset_enc_request", enc_request, 0);
    check("midreset_rdata", cpu_rdata, 0);
    check("midreset_ack_error", ack_error, 0);
    check("midreset_stall", cpu_stall, 1);
    check("midreset_enc_address", enc_address, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 16'h0020, 16'h0000, 16'h2222, rd, reqs, stalls);
    check("after_reset_cache_miss", reqs, 1);
    check("after_reset_rdata", rd, 16'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_sram_bridge.md
Name: hack_sram_bridge

Overview:
- Sits directly upstream of spi_sram_encoder. Converts the Hack CPU data-memory port (address, write strobe, write data, read data) into the encoder's request/busy handshake.
- Stalls the CPU for the duration of every SPI transaction.
- Holds a one-entry write-allocate, write-through read cache (last address/data), so repeated reads of the same word complete with zero wait states.
- Includes a request-acknowledge watchdog that re-issues requests the encoder never accepts.

Parameters:
- WORD_WIDTH, 16, data word width.
- ADDRESS_WIDTH, 16, address width.
- ACK_TIMEOUT, 8, cycles to wait in WAIT_BUSY for enc_busy to rise before re-issuing; minimum 2.
- CACHE_EN, 1, 1 enables the one-entry read cache; 0 makes every read a miss.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- cpu_mem_req  in  1  CPU requests a data-memory access this cycle.
- cpu_address  in  ADDRESS_WIDTH  access address.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_wdata  in  WORD_WIDTH  write data.
- cpu_rdata  out  WORD_WIDTH  read data; valid in the cycle the access completes.
- cpu_stall  out  1  CPU must hold its state and inputs while 1.
- enc_request  out  1  one-cycle request pulse to encoder.
- enc_busy  in  1  encoder transaction in progress.
- enc_initialized  in  1  encoder has configured the SRAM and is usable.
- enc_address  out  ADDRESS_WIDTH  latched address.
- enc_write_enable  out  1  latched write flag.
- enc_wdata  out  WORD_WIDTH  latched write data to encoder.
- enc_rdata  in  WORD_WIDTH  read data from encoder; valid when enc_busy falls.
- ack_error  out  1  sticky; set on any watchdog re-issue.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=WAIT_INIT; enc_request=0; cache valid=0; cpu_rdata=0; ack_error=0.
  - enc_address, enc_write_enable and enc_wdata = 0; watchdog counter=0.
  - Reset mid-transaction aborts immediately; no completion is reported.
- States: WAIT_INIT, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- WAIT_INIT: cpu_stall=1. Go to IDLE when enc_initialized=1.
- IDLE:
  - hit = CACHE_EN & valid & (tag==cpu_address) & ~cpu_write.
  - cpu_stall = cpu_mem_req & ~hit (combinational).
  - On a hit: cpu_rdata is driven from cache data combinationally; stay in IDLE; zero-wait.
  - On cpu_mem_req & ~hit: latch cpu_address, cpu_write and cpu_wdata into the enc_* registers; go to ISSUE.
  - If there is no request: stay in IDLE.
- ISSUE:
  - cpu_stall=1.
  - If enc_initialized & ~enc_busy: enc_request=1 for exactly this cycle; clear watchdog; go to WAIT_BUSY.
  - Otherwise hold with enc_request=0.
- WAIT_BUSY:
  - cpu_stall=1.
  - enc_busy=1 goes to WAIT_DONE.
  - Otherwise increment the watchdog. When it reaches ACK_TIMEOUT-1: set ack_error and return to ISSUE to re-issue with the same latched fields.
- WAIT_DONE:
  - cpu_stall=1.
  - When enc_busy=0 on a read: capture enc_rdata into the cpu_rdata register and into the cache (tag=enc_address, valid=1).
  - When enc_busy=0 on a write: cache tag=enc_address, data=enc_wdata, valid=1 (write-allocate, write-through).
  - Go to DONE.
- DONE:
  - cpu_stall=0 and cpu_rdata holds the captured word for this cycle; the CPU advances.
  - Go to IDLE unconditionally. A new request is evaluated in the next cycle.
- cpu_rdata outside hits and DONE: holds the last registered value.
- enc_* address and data outputs: stable from the ISSUE entry until leaving DONE.
- Minimum miss latency: ISSUE(1) + WAIT_BUSY(≥1) + encoder busy time + DONE(1).
- A write to the cached address updates the cache, so a stale read is impossible.
- CPU inputs may change only when cpu_stall=0 at a clock edge. Changes while stalled are ignored because the fields are latched.
- enc_initialized dropping mid-transaction: the current transaction completes; the next ISSUE waits for enc_initialized.

Test Plan:
- Hold enc_initialized=0 for 20 cycles with cpu_mem_req=1 -> cpu_stall=1 and no enc_request throughout. After enc_initialized rises, exactly one enc_request pulse follows.
- Write 0xBEEF to 0x0010 -> one enc_request with enc_write_enable=1, enc_address=0x0010, enc_wdata=0xBEEF. cpu_stall drops for one cycle after enc_busy falls.
- Read 0x0010 immediately after that write -> no enc_request, cpu_stall=0, cpu_rdata=0xBEEF in the same cycle.
- Read 0x0020 (miss), encoder model returns 0x1234 -> one enc_request; cpu_rdata=0x1234 in DONE. A repeat read of 0x0020 hits with zero wait. A read of 0x0010 then misses.
- Encoder model ignores the first request (enc_busy stays 0) -> re-issue after ACK_TIMEOUT=8 cycles with identical fields. ack_error=1 sticky. The access completes normally on the second pulse.
- Assert reset=0 during WAIT_DONE -> next edge: enc_request=0, cpu_rdata=0, ack_error=0, state WAIT_INIT. The following read of a previously cached address misses.
